// File: rtl/cdc_bus_tx_arbiter.sv
// Round-robin owner of one CDC bus: latches the winning word and runs a four-phase enable/ack handshake.
// Grant one cycle after request; 4+2*NUM_STAGES cycles per word; later requesters hold until granted.
module cdc_bus_tx_arbiter #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_REQ    = 2,
    parameter int NUM_STAGES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [BUS_WIDTH-1:0]           unsync_bus,
    output logic                           bus_enable,
    input  logic                           ack_async,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    input  logic                           err_clr
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_REL} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         ptr, ptr_nxt, win, idx;
    logic [PW:0]           sum;
    logic                  win_vld;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [NUM_STAGES-1:0] ack_meta;
    logic                  ack_sync;
    logic [BUS_WIDTH-1:0]  bus_nxt;
    logic [NUM_REQ-1:0]    grant_nxt;
    logic                  en_nxt, done_nxt, err_set;

    assign ack_sync = ack_meta[NUM_STAGES-1];
    assign busy     = (state != IDLE);

    // First asserted request at or above ptr, wrapping around.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            idx = sum[PW-1:0];
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        bus_nxt   = unsync_bus;
        grant_nxt = '0;
        en_nxt    = bus_enable;
        done_nxt  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    bus_nxt   = req_data[win*BUS_WIDTH +: BUS_WIDTH];
                    grant_nxt = NUM_REQ'(1) << win;
                    ptr_nxt   = (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                en_nxt    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack arriving on the timeout edge still counts as a good transfer.
                if (ack_sync) begin
                    en_nxt    = 1'b0;
                    state_nxt = WAIT_REL;
                end else if (cnt == CW'(TIMEOUT-1)) begin
                    en_nxt    = 1'b0;
                    err_set   = 1'b1;
                    state_nxt = WAIT_REL;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!ack_sync) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            ack_meta   <= '0;
            unsync_bus <= '0;
            grant      <= '0;
            bus_enable <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            ack_meta   <= {ack_meta[NUM_STAGES-2:0], ack_async};
            unsync_bus <= bus_nxt;
            grant      <= grant_nxt;
            bus_enable <= en_nxt;
            done       <= done_nxt;
            if (err_set)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdc_bus_tx_arbiter.sv
// Directed bench for cdc_bus_tx_arbiter: loopback, dead and 20-cycle-delayed destination ack models.
module tb_cdc_bus_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  grant;
    logic [7:0]  unsync_bus;
    logic        bus_enable;
    logic        ack_async;
    logic        busy;
    logic        done;
    logic        err;
    logic        err_clr;

    int          ack_mode;  // 0: dead, 1: loopback, 2: delayed by 20 cycles
    logic [31:0] hist;
    int          checks   = 0;
    int          failures = 0;

    cdc_bus_tx_arbiter #(.BUS_WIDTH(8), .NUM_REQ(2), .NUM_STAGES(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
        .unsync_bus(unsync_bus), .bus_enable(bus_enable), .ack_async(ack_async),
        .busy(busy), .done(done), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) hist <= '0;
        else     hist <= {hist[30:0], bus_enable};
    end

    assign ack_async = (ack_mode == 1) ? bus_enable : (ack_mode == 2) ? hist[19] : 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs until done (bounded), measuring one handshake.
    task automatic watch(input int budget, input logic [7:0] dat, output int n, output int be_cnt,
                         output int busy_cnt, output int gnt_cnt, output int bad_dat,
                         output bit seen_done, output bit err_at_done);
        n = 0; be_cnt = 0; busy_cnt = 0; gnt_cnt = 0; bad_dat = 0;
        seen_done = 1'b0; err_at_done = 1'b0;
        while (n < budget) begin
            tick;
            n++;
            if (bus_enable) be_cnt++;
            if (busy) busy_cnt++;
            if (grant != 2'b00) gnt_cnt++;
            if (unsync_bus != dat) bad_dat++;
            if (done) begin
                seen_done   = 1'b1;
                err_at_done = err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        checks++; if (unsync_bus !== 8'h00) begin failures++; $display("FAIL reset_bus: got %h expected 00", unsync_bus); end
        checks++; if (bus_enable !== 1'b0) begin failures++; $display("FAIL reset_enable: got %b expected 0", bus_enable); end
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        int n, be, bz, gc, bad;
        bit sd, ed;
        ack_mode = 1;
        req_data = 16'h00A5;
        req = 2'b01;
        tick;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant: got %b expected 01", grant); end
        checks++; if (unsync_bus !== 8'hA5) begin failures++; $display("FAIL single_bus: got %h expected a5", unsync_bus); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy); end
        req = 2'b00;
        watch(20, 8'hA5, n, be, bz, gc, bad, sd, ed);
        checks++; if (!sd || n != 7) begin failures++; $display("FAIL single_done_delay: got %0d (seen %b) expected 7", n, sd); end
        checks++; if (be != 3) begin failures++; $display("FAIL single_enable_cycles: got %0d expected 3", be); end
        checks++; if (gc != 0) begin failures++; $display("FAIL single_grant_pulse: got %0d extra grant cycles expected 0", gc); end
        checks++; if (bad != 0) begin failures++; $display("FAIL single_bus_stable: got %0d bad cycles expected 0", bad); end
        checks++; if (ed !== 1'b0) begin failures++; $display("FAIL single_err: got %b expected 0", ed); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] gv [4];
        logic [7:0] gd [4];
        int         gt [4];
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
        int k = 0;
        int n, be, bz, gc, bad;
        bit sd, ed;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ack_mode = 1;
        req_data = 16'h2211;
        req = 2'b11;
        for (int c = 1; c <= 60; c++) begin
            tick;
            if (grant != 2'b00) begin
                gv[k] = grant; gd[k] = unsync_bus; gt[k] = c;
                k++;
                if (k == 4) break;
            end
        end
        req = 2'b00;
        checks++; if (k != 4) begin failures++; $display("FAIL b2b_grant_count: got %0d expected 4", k); end
        for (int i = 0; i < k; i++) begin
            checks++; if (gv[i] !== exp_g[i]) begin failures++; $display("FAIL b2b_grant%0d: got %b expected %b", i, gv[i], exp_g[i]); end
            checks++; if (gd[i] !== exp_d[i]) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", i, gd[i], exp_d[i]); end
            if (i > 0) begin
                checks++; if (gt[i] - gt[i-1] != 8) begin failures++; $display("FAIL b2b_spacing%0d: got %0d expected 8", i, gt[i] - gt[i-1]); end
            end
        end
        watch(20, 8'h22, n, be, bz, gc, bad, sd, ed);
        checks++; if (!sd) begin failures++; $display("FAIL b2b_drain: got no done expected done"); end
    endtask

    task automatic test_timeout;
        int n, be, bz, gc, bad;
        bit sd, ed;
        ack_mode = 0;
        req_data = 16'h0077;
        req = 2'b01;
        tick;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL to_grant: got %b expected 01", grant); end
        req = 2'b00;
        watch(100, 8'h77, n, be, bz, gc, bad, sd, ed);
        checks++; if (!sd || n != 66) begin failures++; $display("FAIL to_done_delay: got %0d (seen %b) expected 66", n, sd); end
        checks++; if (be != 64) begin failures++; $display("FAIL to_enable_cycles: got %0d expected 64", be); end
        checks++; if (ed !== 1'b1) begin failures++; $display("FAIL to_err_set: got %b expected 1", ed); end
        // err must survive a good transfer
        ack_mode = 1;
        req_data = 16'h9900;
        req = 2'b10;
        tick;
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL to_next_grant: got %b expected 10", grant); end
        req = 2'b00;
        watch(20, 8'h99, n, be, bz, gc, bad, sd, ed);
        checks++; if (!sd || n != 7) begin failures++; $display("FAIL to_good_done: got %0d (seen %b) expected 7", n, sd); end
        checks++; if (ed !== 1'b1) begin failures++; $display("FAIL to_err_sticky: got %b expected 1", ed); end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_clr: got %b expected 0", err); end
        // clear on the abort edge loses to the set
        ack_mode = 0;
        req_data = 16'h0055;
        req = 2'b01;
        tick;
        req = 2'b00;
        repeat (64) tick;
        checks++; if (bus_enable !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL to_pre_abort: got en=%b err=%b expected en=1 err=0", bus_enable, err); end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_set_wins: got %b expected 1", err); end
        checks++; if (bus_enable !== 1'b0) begin failures++; $display("FAIL to_abort_enable: got %b expected 0", bus_enable); end
        watch(10, 8'h55, n, be, bz, gc, bad, sd, ed);
        checks++; if (!sd || n != 1) begin failures++; $display("FAIL to_abort_done: got %0d (seen %b) expected 1", n, sd); end
    endtask

    task automatic test_delayed_ack;
        int n, be, bz, gc, bad;
        bit sd, ed;
        repeat (25) tick;
        ack_mode = 2;
        req_data = 16'h003C;
        req = 2'b01;
        tick;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL dly_grant: got %b expected 01", grant); end
        req = 2'b00;
        watch(100, 8'h3C, n, be, bz, gc, bad, sd, ed);
        checks++; if (!sd || n != 47) begin failures++; $display("FAIL dly_done_delay: got %0d (seen %b) expected 47", n, sd); end
        checks++; if (be != 23) begin failures++; $display("FAIL dly_enable_cycles: got %0d expected 23", be); end
        checks++; if (bz != 46) begin failures++; $display("FAIL dly_busy_cycles: got %0d expected 46", bz); end
        checks++; if (bad != 0) begin failures++; $display("FAIL dly_bus_stable: got %0d bad cycles expected 0", bad); end
        ack_mode = 1;
    endtask

    task automatic test_reset_mid;
        int n, be, bz, gc, bad;
        bit sd, ed;
        ack_mode = 1;
        req_data = 16'h1144;
        req = 2'b01;
        tick;
        req = 2'b00;
        tick;
        checks++; if (bus_enable !== 1'b1) begin failures++; $display("FAIL rmid_enable_up: got %b expected 1", bus_enable); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (bus_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_idle: got en=%b busy=%b expected 0 0", bus_enable, busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0 || grant !== 2'b00) begin failures++; $display("FAIL rmid_outputs: got done=%b err=%b grant=%b expected 0 0 00", done, err, grant); end
        req = 2'b11;
        tick;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rmid_ptr_reset: got %b expected 01", grant); end
        req = 2'b00;
        watch(20, 8'h44, n, be, bz, gc, bad, sd, ed);
        checks++; if (!sd) begin failures++; $display("FAIL rmid_drain: got no done expected done"); end
        req = 2'b01;
        tick;
        req = 2'b00;
        tick;
        req = 2'b10;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL rmid_pending_grant: got %b expected 10", grant); end
        checks++; if (unsync_bus !== 8'h11) begin failures++; $display("FAIL rmid_pending_data: got %h expected 11", unsync_bus); end
        req = 2'b00;
        watch(20, 8'h11, n, be, bz, gc, bad, sd, ed);
        checks++; if (!sd) begin failures++; $display("FAIL rmid_pending_drain: got no done expected done"); end
    endtask

    task automatic test_req_pulse_busy;
        int n, be, bz, gc, bad;
        bit sd, ed;
        int idle_bad = 0;
        ack_mode = 1;
        req_data = 16'h6655;
        req = 2'b01;
        tick;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL pulse_first_grant: got %b expected 01", grant); end
        req = 2'b00;
        repeat (2) tick;
        req = 2'b10;
        tick;
        req = 2'b00;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pulse_busy: got %b expected 1", busy); end
        watch(20, 8'h55, n, be, bz, gc, bad, sd, ed);
        checks++; if (!sd || gc != 0) begin failures++; $display("FAIL pulse_no_grant: got %0d grant cycles (seen done %b) expected 0", gc, sd); end
        for (int i = 0; i < 10; i++) begin
            tick;
            if (grant != 2'b00 || busy) idle_bad++;
        end
        checks++; if (idle_bad != 0) begin failures++; $display("FAIL pulse_no_extra_xfer: got %0d active cycles expected 0", idle_bad); end
    endtask

    initial begin
        rst      = 1'b1;
        req      = 2'b00;
        req_data = 16'h0000;
        err_clr  = 1'b0;
        ack_mode = 0;
        test_reset;
        test_single;
        test_back_to_back;
        test_timeout;
        test_delayed_ack;
        test_reset_mid;
        test_req_pulse_busy;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
